better_neighbors_in_my_cluster: RTL and testbench

Routing-decision stage of the node pipeline. It runs after the find-my-best stage and before the winner-policy stage.
- Scans the neighbor table in shared memory.
- Collects the IDs of same-cluster neighbors whose Q-value beats the node's own best cost, and writes them to the betterneighbors list and count.
- Reports the single best such neighbor.
- Is the sole memory master while start=1 and done=0.

---
 rtl/better_neighbors_in_my_cluster_pkg.sv | 18 +
 rtl/bnimc_mem_port.sv | 34 +++
 rtl/better_neighbors_in_my_cluster.sv | 174 +++++++++++++++++
 tb/tb_better_neighbors_in_my_cluster.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/better_neighbors_in_my_cluster_pkg.sv
// better_neighbors_in_my_cluster_pkg: word width, shared memory map and scan FSM states
package better_neighbors_in_my_cluster_pkg;
  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] NEIGHBOR_ID_BASE = 16'h0048;
  localparam logic [WORD_WIDTH-1:0] CLUSTER_ID_BASE  = 16'h00C8;
  localparam logic [WORD_WIDTH-1:0] QVALUE_BASE      = 16'h01C8;
  localparam logic [WORD_WIDTH-1:0] BETTER_BASE      = 16'h0668;
  localparam logic [WORD_WIDTH-1:0] NCOUNT_ADDR      = 16'h068A;
  localparam logic [WORD_WIDTH-1:0] BCOUNT_ADDR      = 16'h068C;
  localparam logic [WORD_WIDTH-1:0] SINKCNT_BASE     = 16'h068E;
  typedef enum logic [3:0] {
    IDLE, RD_NCNT, RD_CID, CHK_CID, RD_Q, CHK_Q, RD_NID, WR_BN, RD_SCNT, WR_BCNT, DONE
  } state_t;
  function automatic logic [WORD_WIDTH-1:0] elem_addr(input logic [WORD_WIDTH-1:0] base,
                                                      input logic [WORD_WIDTH-1:0] idx);
    return base + (idx << 1);
  endfunction
endpackage

// File: rtl/bnimc_mem_port.sv
// bnimc_mem_port: registers the bus address/data, pulses wr_en for one cycle and flags read capture
module bnimc_mem_port
  import better_neighbors_in_my_cluster_pkg::*;
(
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  ld,
  input  logic                  wr,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_data,
  output logic [WORD_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic                  rd_valid
);
  logic issued;
  // issued marks the cycle the address is on the bus; data_in is valid the cycle after
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      address  <= '0;
      data_out <= '0;
      wr_en    <= 1'b0;
      issued   <= 1'b0;
      rd_valid <= 1'b0;
    end else if (en) begin
      if (ld || wr) address <= req_addr;
      if (wr) data_out <= req_data;
      wr_en    <= wr;
      issued   <= ld;
      rd_valid <= issued;
    end
  end
endmodule

// File: rtl/better_neighbors_in_my_cluster.sv
// better_neighbors_in_my_cluster: lists same-cluster neighbors beating mybest and tracks the best one; BNIMC_TIE_EN also lists equal-cost neighbors
module better_neighbors_in_my_cluster
  import better_neighbors_in_my_cluster_pkg::*;
#(
  parameter int MAX_BETTER = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] mybest,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighbor_id,
  output logic [WORD_WIDTH-1:0] nextsinks,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done
);
  localparam logic [WORD_WIDTH-1:0] CAP = WORD_WIDTH'(MAX_BETTER);
  state_t state, state_n;
  logic [WORD_WIDTH-1:0] i, i_n, n, n_n, cnt, cnt_n, val, val_n;
  logic [WORD_WIDTH-1:0] besthop_n, bestvalue_n, bestneighbor_id_n, nextsinks_n, req_addr, req_data;
  logic lst, lst_n, nb, nb_n, ld, wr, adv, rd_valid, better, room, lower;
`ifdef BNIMC_TIE_EN
  assign better = val <= mybest;
`else
  assign better = val < mybest;
`endif
  assign room  = cnt < CAP;
  assign lower = val < bestvalue;
  assign done  = state == DONE;
  always_comb begin
    state_n = state;
    i_n = i;
    n_n = n;
    cnt_n = cnt;
    val_n = val;
    lst_n = lst;
    nb_n = nb;
    besthop_n = besthop;
    bestvalue_n = bestvalue;
    bestneighbor_id_n = bestneighbor_id;
    nextsinks_n = nextsinks;
    ld = 1'b0;
    wr = 1'b0;
    adv = 1'b0;
    req_addr = '0;
    req_data = cnt;
    unique case (state)
      IDLE: if (start) begin
        state_n = RD_NCNT;
        ld = 1'b1;
        req_addr = NCOUNT_ADDR;
        i_n = '0;
        cnt_n = '0;
        bestvalue_n = mybest;
        besthop_n = '1;
        bestneighbor_id_n = '1;
        nextsinks_n = '0;
      end
      RD_NCNT: if (rd_valid) begin
        n_n = data_in;
        state_n = data_in == '0 ? WR_BCNT : RD_CID;
        wr = data_in == '0;
        ld = data_in != '0;
        req_addr = data_in == '0 ? BCOUNT_ADDR : CLUSTER_ID_BASE;
      end
      RD_CID: if (rd_valid) begin
        val_n = data_in;
        state_n = CHK_CID;
      end
      CHK_CID: if (val == my_cluster_id) begin
        state_n = RD_Q;
        ld = 1'b1;
        req_addr = elem_addr(QVALUE_BASE, i);
      end else adv = 1'b1;
      RD_Q: if (rd_valid) begin
        val_n = data_in;
        state_n = CHK_Q;
      end
      // a full list still needs the neighbor ID when this neighbor becomes the new best
      CHK_Q: begin
        lst_n = better && room;
        nb_n = better && lower;
        if (better && (room || lower)) begin
          state_n = RD_NID;
          ld = 1'b1;
          req_addr = elem_addr(NEIGHBOR_ID_BASE, i);
        end else adv = 1'b1;
      end
      RD_NID: if (rd_valid) begin
        if (nb) begin
          besthop_n = i;
          bestvalue_n = val;
          bestneighbor_id_n = data_in;
        end
        if (lst) begin
          state_n = WR_BN;
          wr = 1'b1;
          req_addr = elem_addr(BETTER_BASE, cnt);
          req_data = data_in;
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = RD_SCNT;
          ld = 1'b1;
          req_addr = elem_addr(SINKCNT_BASE, i);
        end
      end
      WR_BN: if (nb) begin
        state_n = RD_SCNT;
        ld = 1'b1;
        req_addr = elem_addr(SINKCNT_BASE, i);
      end else adv = 1'b1;
      RD_SCNT: if (rd_valid) begin
        nextsinks_n = data_in;
        adv = 1'b1;
      end
      WR_BCNT: state_n = DONE;
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      i_n = i + 1'b1;
      state_n = i_n == n ? WR_BCNT : RD_CID;
      wr = i_n == n;
      ld = i_n != n;
      req_addr = i_n == n ? BCOUNT_ADDR : elem_addr(CLUSTER_ID_BASE, i_n);
    end
  end
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      i <= '0;
      n <= '0;
      cnt <= '0;
      val <= '0;
      lst <= 1'b0;
      nb <= 1'b0;
      besthop <= '0;
      bestvalue <= '0;
      bestneighbor_id <= '0;
      nextsinks <= '0;
    end else if (en) begin
      state <= state_n;
      i <= i_n;
      n <= n_n;
      cnt <= cnt_n;
      val <= val_n;
      lst <= lst_n;
      nb <= nb_n;
      besthop <= besthop_n;
      bestvalue <= bestvalue_n;
      bestneighbor_id <= bestneighbor_id_n;
      nextsinks <= nextsinks_n;
    end
  end
  bnimc_mem_port u_mem_port (
    .clock   (clock),
    .nrst    (nrst),
    .en      (en),
    .ld      (ld),
    .wr      (wr),
    .req_addr(req_addr),
    .req_data(req_data),
    .address (address),
    .data_out(data_out),
    .wr_en   (wr_en),
    .rd_valid(rd_valid)
  );
endmodule

// File: tb/tb_better_neighbors_in_my_cluster.sv
// tb_better_neighbors_in_my_cluster: directed scans against a synchronous-read memory model
module tb_better_neighbors_in_my_cluster;
  logic clock = 1'b0, nrst = 1'b0, en = 1'b1, start = 1'b0, wr_en, done;
  logic [15:0] address, data_in, my_cluster_id = 16'd0, mybest = 16'd0;
  logic [15:0] besthop, bestvalue, bestneighbor_id, nextsinks, data_out;
  logic [15:0] mem [0:32767];
  logic [15:0] wa[$], wd[$];
  int checks = 0, errors = 0;

  better_neighbors_in_my_cluster dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start), .address(address), .wr_en(wr_en),
    .data_in(data_in), .my_cluster_id(my_cluster_id), .mybest(mybest), .besthop(besthop),
    .bestvalue(bestvalue), .bestneighbor_id(bestneighbor_id), .nextsinks(nextsinks),
    .data_out(data_out), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    data_in <= mem[address[15:1]];
    if (wr_en) mem[address[15:1]] = data_out;
    if (wr_en && en) begin
      wa.push_back(address);
      wd.push_back(data_out);
    end
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]] = v;
  endtask

  task automatic put_nb(input int k, input logic [15:0] c, input logic [15:0] q,
                        input logic [15:0] id, input logic [15:0] sc);
    poke(16'h00C8 + 16'(2 * k), c);
    poke(16'h01C8 + 16'(2 * k), q);
    poke(16'h0048 + 16'(2 * k), id);
    poke(16'h068E + 16'(2 * k), sc);
  endtask

  task automatic clear_mem();
    foreach (mem[j]) mem[j] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clock);
    nrst = 1'b0;
    start = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clock);
    wa.delete();
    wd.delete();
    nrst = 1'b1;
  endtask

  task automatic scan_setup();
    clear_mem();
    poke(16'h068A, 16'd3);
    put_nb(0, 16'd1, 16'd5, 16'd7, 16'd2);
    put_nb(1, 16'd2, 16'd1, 16'h0055, 16'h0066);
    put_nb(2, 16'd1, 16'd3, 16'd9, 16'd4);
    my_cluster_id = 16'd1;
    mybest = 16'd10;
  endtask

  task automatic go(input int budget);
    start = 1'b1;
    for (int c = 0; c < budget && done !== 1'b1; c++) @(negedge clock);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout: done=%b after %0d cycles, expected 1", done, budget);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({address, data_out, besthop, bestvalue, bestneighbor_id, nextsinks} !== 96'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h dout=%h hop=%h val=%h id=%h sinks=%h, expected all 0",
               address, data_out, besthop, bestvalue, bestneighbor_id, nextsinks);
    end
    checks++;
    if ({wr_en, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: wr_en=%b done=%b, expected 0 0", wr_en, done);
    end
    nrst = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (wa.size() != 0 || done !== 1'b0 || address !== 16'h0) begin
      errors++;
      $display("FAIL idle_hold: writes=%0d done=%b addr=%h, expected 0 0 0000", wa.size(), done, address);
    end
  endtask

  task automatic test_n_zero();
    do_reset();
    clear_mem();
    poke(16'h068C, 16'hBEEF);
    my_cluster_id = 16'd1;
    mybest = 16'd33;
    go(200);
    checks++;
    if (wa.size() != 1 || wa[0] !== 16'h068C || wd[0] !== 16'h0000) begin
      errors++;
      $display("FAIL n0_writes: count=%0d addr=%h data=%h, expected 1 068c 0000", wa.size(), wa[0], wd[0]);
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'hFFFF, 16'd33, 16'hFFFF, 16'd0}) begin
      errors++;
      $display("FAIL n0_best: hop=%h val=%h id=%h sinks=%h, expected ffff 0021 ffff 0000",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
    start = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b0 || wa.size() != 1) begin
      errors++;
      $display("FAIL done_hold: done=%b wr_en=%b writes=%0d, expected 1 0 1", done, wr_en, wa.size());
    end
  endtask

  task automatic test_scan();
    do_reset();
    scan_setup();
    go(500);
    checks++;
    if (wa.size() != 3 || {wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
        {16'h0668, 16'd7, 16'h066A, 16'd9, 16'h068C, 16'd2}) begin
      errors++;
      $display("FAIL scan_writes: count=%0d %h<-%h %h<-%h %h<-%h, expected 3 0668<-0007 066a<-0009 068c<-0002",
               wa.size(), wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'd2, 16'd3, 16'd9, 16'd4}) begin
      errors++;
      $display("FAIL scan_best: hop=%h val=%h id=%h sinks=%h, expected 0002 0003 0009 0004",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
    checks++;
    if ({mem[16'h0668 >> 1], mem[16'h066A >> 1], mem[16'h068C >> 1]} !== {16'd7, 16'd9, 16'd2}) begin
      errors++;
      $display("FAIL scan_image: %h %h %h, expected 0007 0009 0002",
               mem[16'h0668 >> 1], mem[16'h066A >> 1], mem[16'h068C >> 1]);
    end
  endtask

  task automatic test_tie();
    logic [15:0] ea [2];
    logic [15:0] ed [2];
    int ew;
    do_reset();
    clear_mem();
    poke(16'h068A, 16'd1);
    put_nb(0, 16'd1, 16'd10, 16'd5, 16'd6);
    my_cluster_id = 16'd1;
    mybest = 16'd10;
`ifdef BNIMC_TIE_EN
    ew = 2;
    ea = '{16'h0668, 16'h068C};
    ed = '{16'h0005, 16'h0001};
`else
    ew = 1;
    ea = '{16'h068C, 16'h0000};
    ed = '{16'h0000, 16'h0000};
`endif
    go(300);
    checks++;
    if (wa.size() != ew) begin
      errors++;
      $display("FAIL tie_count: writes=%0d, expected %0d", wa.size(), ew);
    end
    for (int k = 0; k < ew; k++) begin
      checks++;
      if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
        errors++;
        $display("FAIL tie_write%0d: %h<-%h, expected %h<-%h", k, wa[k], wd[k], ea[k], ed[k]);
      end
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'hFFFF, 16'd10, 16'hFFFF, 16'd0}) begin
      errors++;
      $display("FAIL tie_best: hop=%h val=%h id=%h sinks=%h, expected ffff 000a ffff 0000",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    clear_mem();
    poke(16'h068A, 16'd20);
    poke(16'h0688, 16'hDEAD);
    for (int k = 0; k < 20; k++)
      put_nb(k, 16'd3, (k >= 18) ? 16'd2 : 16'(40 + k), 16'(200 + k), 16'(300 + k));
    my_cluster_id = 16'd3;
    mybest = 16'd100;
    go(2000);
    checks++;
    if (wa.size() != 17) begin
      errors++;
      $display("FAIL sat_count: writes=%0d, expected 17", wa.size());
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wa[k] !== 16'h0668 + 16'(2 * k) || wd[k] !== 16'(200 + k)) begin
        errors++;
        $display("FAIL sat_list%0d: %h<-%h, expected %h<-%h", k, wa[k], wd[k],
                 16'h0668 + 16'(2 * k), 16'(200 + k));
      end
    end
    checks++;
    if (wa[16] !== 16'h068C || wd[16] !== 16'd16) begin
      errors++;
      $display("FAIL sat_bcount: %h<-%h, expected 068c<-0010", wa[16], wd[16]);
    end
    checks++;
    if (mem[16'h0688 >> 1] !== 16'hDEAD) begin
      errors++;
      $display("FAIL sat_overrun: mem[0688]=%h, expected dead", mem[16'h0688 >> 1]);
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'd18, 16'd2, 16'd218, 16'd318}) begin
      errors++;
      $display("FAIL sat_best: hop=%0d val=%0d id=%0d sinks=%0d, expected 18 2 218 318",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
  endtask

  task automatic test_en_freeze();
    logic [97:0] snap;
    do_reset();
    scan_setup();
    start = 1'b1;
    for (int c = 0; c < 200 && wr_en !== 1'b1; c++) @(negedge clock);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL freeze_wait: wr_en=%b, expected 1 within 200 cycles", wr_en);
    end
    snap = {address, wr_en, data_out, besthop, bestvalue, bestneighbor_id, nextsinks, done};
    en = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if ({address, wr_en, data_out, besthop, bestvalue, bestneighbor_id, nextsinks, done} !== snap) begin
        errors++;
        $display("FAIL freeze_hold: outputs=%h, expected %h",
                 {address, wr_en, data_out, besthop, bestvalue, bestneighbor_id, nextsinks, done}, snap);
      end
    end
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL freeze_writes: writes=%0d while disabled, expected 0", wa.size());
    end
    en = 1'b1;
    go(500);
    checks++;
    if (wa.size() != 3 || {wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
        {16'h0668, 16'd7, 16'h066A, 16'd9, 16'h068C, 16'd2}) begin
      errors++;
      $display("FAIL freeze_image: count=%0d %h<-%h %h<-%h %h<-%h, expected 3 0668<-0007 066a<-0009 068c<-0002",
               wa.size(), wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'd2, 16'd3, 16'd9, 16'd4}) begin
      errors++;
      $display("FAIL freeze_best: hop=%h val=%h id=%h sinks=%h, expected 0002 0003 0009 0004",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
  endtask

  task automatic test_reset_mid();
    int pre;
    do_reset();
    scan_setup();
    start = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mid_running: done=%b at cycle 20, expected 0", done);
    end
    pre = wa.size();
    nrst = 1'b0;
    #1;
    checks++;
    if ({address, data_out, besthop, bestvalue, bestneighbor_id, nextsinks, wr_en, done} !== 98'd0) begin
      errors++;
      $display("FAIL mid_reset: addr=%h dout=%h hop=%h val=%h id=%h sinks=%h wr=%b done=%b, expected all 0",
               address, data_out, besthop, bestvalue, bestneighbor_id, nextsinks, wr_en, done);
    end
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (wa.size() != pre || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_nowrite: writes=%0d wr_en=%b, expected %0d 0", wa.size(), wr_en, pre);
    end
    nrst = 1'b1;
    wa.delete();
    wd.delete();
    go(500);
    checks++;
    if (wa.size() != 3 || {wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
        {16'h0668, 16'd7, 16'h066A, 16'd9, 16'h068C, 16'd2}) begin
      errors++;
      $display("FAIL rerun_writes: count=%0d %h<-%h %h<-%h %h<-%h, expected 3 0668<-0007 066a<-0009 068c<-0002",
               wa.size(), wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
    end
    checks++;
    if ({besthop, bestvalue, bestneighbor_id, nextsinks} !== {16'd2, 16'd3, 16'd9, 16'd4}) begin
      errors++;
      $display("FAIL rerun_best: hop=%h val=%h id=%h sinks=%h, expected 0002 0003 0009 0004",
               besthop, bestvalue, bestneighbor_id, nextsinks);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_n_zero();
    test_scan();
    test_tie();
    test_saturate();
    test_en_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
